// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake, ALU request/response and
// writeback/illegal reporting between the issue controller and its peer.
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [5:0]  alu_opcode;
    logic [5:0]  alu_funct;
    logic [31:0] alu_inp1;
    logic [31:0] alu_inp2;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_out;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    // Instruction source and ALU side
    modport master (
        output instr_valid, instr, alu_out,
        input  instr_ready, alu_opcode, alu_funct, alu_inp1, alu_inp2,
               alu_shamt, wb_valid, wb_rd, wb_data, illegal
    );

    // Issue controller side
    modport slave (
        input  instr_valid, instr, alu_out,
        output instr_ready, alu_opcode, alu_funct, alu_inp1, alu_inp2,
               alu_shamt, wb_valid, wb_rd, wb_data, illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue controller for MIPS R-type instructions.
// Each accepted word walks IDLE -> DECODE -> EXEC -> WB; operands come from
// an internal 32x32 register file, the external combinational ALU result is
// captured at the end of EXEC and written back in WB.
module alu_issue_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus,
    input  logic            init_we,
    input  logic [4:0]      init_addr,
    input  logic [31:0]     init_data,
    input  logic [4:0]      dbg_addr,
    output logic [31:0]     dbg_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    // R-type function codes accepted by the decoder
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;

    // ALU request registers; they double as the operand registers and keep
    // their value from one EXEC to the next
    logic [5:0]  alu_opcode_q, alu_opcode_d;
    logic [5:0]  alu_funct_q, alu_funct_d;
    logic [31:0] alu_inp1_q, alu_inp1_d;
    logic [31:0] alu_inp2_q, alu_inp2_d;
    logic [4:0]  alu_shamt_q, alu_shamt_d;

    // Captured result and its destination, presented during WB and held after
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    // Register file and its single write port (preload in IDLE or WB result)
    logic [31:0] rf_q [32];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // Fields of the latched instruction word
    logic [5:0]  f_opcode;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [4:0]  f_shamt;
    logic [5:0]  f_funct;

    assign f_opcode = instr_q[31:26];
    assign f_rs     = instr_q[25:21];
    assign f_rt     = instr_q[20:16];
    assign f_rd     = instr_q[15:11];
    assign f_shamt  = instr_q[10:6];
    assign f_funct  = instr_q[5:0];

    logic        dec_legal;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    // Register 0 reads as zero regardless of storage contents
    assign rs_data  = (f_rs == 5'd0)     ? 32'd0 : rf_q[f_rs];
    assign rt_data  = (f_rt == 5'd0)     ? 32'd0 : rf_q[f_rt];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

    // Legality of the latched word: R-type opcode with a supported funct
    always_comb begin
        dec_legal = 1'b0;
        if (f_opcode == 6'd0) begin
            case (f_funct)
                FN_SLL, FN_SRL, FN_SRA,
                FN_ADD, FN_ADDU, FN_SUB,
                FN_AND, FN_OR, FN_SLTU: dec_legal = 1'b1;
                default:                dec_legal = 1'b0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath next values and register-file write selection
    always_comb begin
        // NOTE: every signal driven here gets a default before the case, so
        // no path leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        instr_d      = instr_q;
        alu_opcode_d = alu_opcode_q;
        alu_funct_d  = alu_funct_q;
        alu_inp1_d   = alu_inp1_q;
        alu_inp2_d   = alu_inp2_q;
        alu_shamt_d  = alu_shamt_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        rf_we        = 1'b0;
        rf_waddr     = init_addr;
        rf_wdata     = init_data;

        case (state_q)
            IDLE: begin
                // Preload and acceptance may coincide; DECODE then reads
                // the freshly written value one edge later.
                rf_we = init_we && (init_addr != 5'd0);
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_legal) begin
                    alu_opcode_d = f_opcode;
                    alu_funct_d  = f_funct;
                    alu_inp1_d   = rs_data;
                    alu_inp2_d   = rt_data;
                    alu_shamt_d  = f_shamt;
                    state_d      = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                wb_rd_d   = f_rd;
                wb_data_d = bus.alu_out;
                state_d   = WB;
            end
            WB: begin
                rf_we    = (wb_rd_q != 5'd0);
                rf_waddr = wb_rd_q;
                rf_wdata = wb_data_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: latched word, ALU request, captured result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            instr_q      <= '0;
            alu_opcode_q <= '0;
            alu_funct_q  <= '0;
            alu_inp1_q   <= '0;
            alu_inp2_q   <= '0;
            alu_shamt_q  <= '0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            instr_q      <= instr_d;
            alu_opcode_q <= alu_opcode_d;
            alu_funct_q  <= alu_funct_d;
            alu_inp1_q   <= alu_inp1_d;
            alu_inp2_q   <= alu_inp2_d;
            alu_shamt_q  <= alu_shamt_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    // Register file storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the register file is cleared by reset, so it is built
            // from flops; a resettable array cannot map onto a RAM macro.
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Output drive
    assign bus.instr_ready = (state_q == IDLE);
    assign bus.illegal     = (state_q == DECODE) && !dec_legal;
    assign bus.wb_valid    = (state_q == WB);
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.alu_opcode  = alu_opcode_q;
    assign bus.alu_funct   = alu_funct_q;
    assign bus.alu_inp1    = alu_inp1_q;
    assign bus.alu_inp2    = alu_inp2_q;
    assign bus.alu_shamt   = alu_shamt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench. The driver predicts every outcome from
// an architectural register-file model and queues it; a monitor compares each
// writeback / illegal pulse against the queue head, including its cycle.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_we = 1'b0;
    logic [4:0]  init_addr = '0;
    logic [31:0] init_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          ill;
        int unsigned cyc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_rf [32];
    logic [5:0]  last_op, last_fn;
    logic [31:0] last_a, last_b;
    logic [4:0]  last_sh;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [5:0]  legal_fn [9] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21,
                                  6'h22, 6'h24, 6'h25, 6'h2B};

    // Behaviour of the external ALU (also used by the reference model)
    function automatic logic [31:0] alu_model(input logic [5:0] fn,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [4:0] sh);
        logic [31:0] r;
        case (fn)
            6'h00:        r = b << sh;
            6'h02:        r = b >> sh;
            6'h03:        r = $signed(b) >>> sh;
            6'h20, 6'h21: r = a + b;
            6'h22:        r = a - b;
            6'h24:        r = a & b;
            6'h25:        r = a | b;
            6'h2B:        r = (a < b) ? 32'd1 : 32'd0;
            default:      r = 32'd0;
        endcase
        return r;
    endfunction

    always_comb bus.alu_out = alu_model(bus.alu_funct, bus.alu_inp1,
                                        bus.alu_inp2, bus.alu_shamt);

    function automatic bit is_legal(input logic [31:0] w);
        return (w[31:26] == 6'd0) &&
               (w[5:0] inside {6'h00, 6'h02, 6'h03, 6'h20, 6'h21,
                               6'h22, 6'h24, 6'h25, 6'h2B});
    endfunction

    // Architectural effect of one accepted word; acc is the accept cycle
    function automatic exp_t predict(input logic [31:0] w, input int unsigned acc);
        exp_t e;
        e.ill  = !is_legal(w);
        e.rd   = '0;
        e.data = '0;
        if (e.ill) begin
            e.cyc = acc;
        end else begin
            last_op = w[31:26];
            last_fn = w[5:0];
            last_a  = ref_rf[w[25:21]];
            last_b  = ref_rf[w[20:16]];
            last_sh = w[10:6];
            e.rd    = w[15:11];
            e.data  = alu_model(last_fn, last_a, last_b, last_sh);
            if (e.rd != 5'd0) ref_rf[e.rd] = e.data;
            e.cyc   = acc + 2;
        end
        e.op = last_op;
        e.fn = last_fn;
        e.a  = last_a;
        e.b  = last_b;
        e.sh = last_sh;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every writeback or illegal pulse must match the queue head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.wb_valid || bus.illegal)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({bus.illegal, bus.wb_valid}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 32'({bus.illegal, bus.wb_valid}), e.ill ? 32'd2 : 32'd1);
                check("event_cycle", cyc, e.cyc);
                if (!e.ill) begin
                    check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                    check("wb_data", bus.wb_data, e.data);
                end
                check("alu_opcode", 32'(bus.alu_opcode), 32'(e.op));
                check("alu_funct", 32'(bus.alu_funct), 32'(e.fn));
                check("alu_inp1", bus.alu_inp1, e.a);
                check("alu_inp2", bus.alu_inp2, e.b);
                check("alu_shamt", 32'(bus.alu_shamt), 32'(e.sh));
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        last_op = '0; last_fn = '0; last_a = '0; last_b = '0; last_sh = '0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.instr_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || !bus.instr_ready) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        wait_ready();
        init_we = 1'b1; init_addr = a; init_data = d;
        @(posedge clk); #1;
        if (a != 5'd0) ref_rf[a] = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    // Offer one word (optionally with a simultaneous preload); returns in DECODE
    task automatic issue(input logic [31:0] w, input bit with_init,
                         input logic [4:0] ia, input logic [31:0] id);
        int unsigned acc;
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr = w;
        if (with_init) begin
            init_we = 1'b1; init_addr = ia; init_data = id;
        end
        @(posedge clk); #1;
        acc = cyc;
        if (with_init && ia != 5'd0) ref_rf[ia] = id;
        exp_q.push_back(predict(w, acc));
        @(negedge clk);
        bus.instr_valid = 1'b0;
        init_we = 1'b0;
    endtask

    task automatic dbg_check(input string name, input logic [4:0] a, input logic [31:0] req);
        dbg_addr = a;
        #1;
        check(name, dbg_data, req);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc_a, acc_b;
        logic [31:0] w;
        logic [5:0]  fn;

        // Reset with preload and instruction traffic that must be ignored
        bus.instr_valid = 1'b1;
        bus.instr = 32'h00221820;
        init_we = 1'b1; init_addr = 5'd7; init_data = 32'h1234;
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        init_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        check("rst_alu_funct", 32'(bus.alu_funct), 32'd0);
        check("rst_alu_inp1", bus.alu_inp1, 32'd0);
        check("rst_alu_inp2", bus.alu_inp2, 32'd0);
        check("rst_alu_shamt", 32'(bus.alu_shamt), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        dbg_check("rst_r7", 5'd7, 32'd0);

        // add r3,r1,r2 with operands visible in EXEC
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd3);
        issue(32'h00221820, 1'b0, '0, '0);
        @(negedge clk);
        check("add_exec_inp1", bus.alu_inp1, 32'd5);
        check("add_exec_inp2", bus.alu_inp2, 32'd3);
        check("add_exec_funct", 32'(bus.alu_funct), 32'h20);
        wait_idle();
        dbg_check("add_r3", 5'd3, 32'd8);
        check("wb_hold_valid", 32'(bus.wb_valid), 32'd0);
        check("wb_hold_rd", 32'(bus.wb_rd), 32'd3);
        check("wb_hold_data", bus.wb_data, 32'd8);

        // sra r4,r2,4 of a negative value
        preload(5'd2, 32'h80000000);
        issue(32'h00022103, 1'b0, '0, '0);
        @(negedge clk);
        check("sra_exec_shamt", 32'(bus.alu_shamt), 32'd4);
        check("sra_exec_inp2", bus.alu_inp2, 32'h80000000);
        wait_idle();
        dbg_check("sra_r4", 5'd4, 32'hF8000000);

        // Non-R-type opcode is rejected
        issue(32'h20010005, 1'b0, '0, '0);
        @(negedge clk);
        check("illegal_ready_after", 32'(bus.instr_ready), 32'd1);
        wait_idle();
        dbg_check("illegal_r1_kept", 5'd1, 32'd5);

        // Destination r0: pulse still appears, register stays zero
        preload(5'd2, 32'd3);
        issue(32'h00220020, 1'b0, '0, '0);
        wait_idle();
        dbg_check("r0_stays_zero", 5'd0, 32'd0);

        // Preload of rs on the acceptance edge: add r6,r5,r1 with r5=100
        issue({6'd0, 5'd5, 5'd1, 5'd6, 5'd0, 6'h20}, 1'b1, 5'd5, 32'd100);
        wait_idle();
        dbg_check("same_edge_r6", 5'd6, 32'd105);

        // Back-to-back with instr_valid held: add r7,r1,r2 then sub r8,r7,r1
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr = {6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20};
        @(posedge clk); #1;
        acc_a = cyc;
        exp_q.push_back(predict(bus.instr, acc_a));
        @(negedge clk);
        init_we = 1'b1; init_addr = 5'd9; init_data = 32'hDEAD;
        bus.instr = {6'd0, 5'd7, 5'd1, 5'd8, 5'd0, 6'h22};
        @(negedge clk);
        init_we = 1'b0;
        wait_ready();
        @(posedge clk); #1;
        acc_b = cyc;
        exp_q.push_back(predict(bus.instr, acc_b));
        check("b2b_accept_gap", acc_b - acc_a, 32'd4);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        wait_idle();
        dbg_check("b2b_r8", 5'd8, 32'd3);
        dbg_check("busy_init_ignored_r9", 5'd9, 32'd0);

        // Reset during EXEC aborts the instruction
        issue(32'h00221820, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        @(posedge clk);
        @(negedge clk);
        check("abort_instr_ready", 32'(bus.instr_ready), 32'd1);
        check("abort_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("abort_alu_inp1", bus.alu_inp1, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        dbg_check("abort_r1", 5'd1, 32'd0);
        dbg_check("abort_r3", 5'd3, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 8; i++) begin
            preload(5'($urandom), $urandom);
        end
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 7) begin
                fn = legal_fn[$urandom_range(0, 8)];
                w = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn};
            end else if (kind == 7) begin
                fn = 6'($urandom);
                for (int k = 0; k < 64 && (fn inside {6'h00, 6'h02, 6'h03, 6'h20, 6'h21,
                                                       6'h22, 6'h24, 6'h25, 6'h2B}); k++)
                    fn = 6'($urandom);
                w = {6'd0, 20'($urandom), fn};
            end else begin
                w = {6'($urandom_range(1, 63)), 26'($urandom)};
            end
            issue(w, ($urandom_range(0, 3) == 0), 5'($urandom), $urandom);
        end
        wait_idle();
        for (int r = 0; r < 32; r++) begin
            dbg_check("final_rf", 5'(r), ref_rf[r]);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
